// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the 1-to-2 demux dispatch controller.
package demux_dispatch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic SEL_B       = 1'b0;
    localparam logic SEL_C       = 1'b1;
    localparam logic MODE_RR     = 1'b0;
    localparam logic MODE_FORCED = 1'b1;

endpackage

// File: rtl/demux_stall_timer.sv
// Down-counter that pulses expire_o after LIMIT enabled cycles, then rearms itself.
module demux_stall_timer #(
    parameter int           W     = 8,
    parameter logic [W-1:0] LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i & ~load_i & (cnt_q == W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LIMIT;
        end else if (en_i) begin
            cnt_d = (cnt_q == W'(1)) ? LIMIT : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LIMIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Steers upstream words to sink B or C (round-robin or forced), redirecting
// stalled round-robin words, and counts deliveries per sink.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W      = 2,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic              force_sel,
    output logic [DATA_W-1:0] out_b_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    output logic [DATA_W-1:0] out_c_data,
    output logic              out_c_valid,
    input  logic              out_c_ready,
    output logic              sel_o,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_c,
    input  logic              clr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tgt_q, tgt_d;
    logic              mode_q, mode_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]  cnt_c_q, cnt_c_d;

    logic tgt_ready, deliver, capture, expire, timer_load, timer_en;

    assign tgt_ready = (tgt_q == SEL_C) ? out_c_ready : out_b_ready;
    assign deliver   = (state_q == SEND) & tgt_ready;
    assign in_ready  = (state_q == IDLE) | deliver;
    assign capture   = in_valid & in_ready;

    // The timer only runs while a round-robin word is stuck on its target.
    assign timer_load = (state_q == IDLE) | deliver;
    assign timer_en   = (state_q == SEND) & ~tgt_ready & (mode_q == MODE_RR);

    demux_stall_timer #(
        .W     (8),
        .LIMIT (8'(STALL_LIMIT))
    ) u_stall_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        rr_d    = rr_q;
        cnt_b_d = cnt_b_q;
        cnt_c_d = cnt_c_q;

        if (deliver && mode_q == MODE_RR) begin
            rr_d = ~tgt_q;
        end

        // A back-to-back capture picks its target from the pointer already advanced above.
        if (capture) begin
            state_d = SEND;
            hold_d  = in_data;
            mode_d  = mode;
            tgt_d   = (mode == MODE_FORCED) ? force_sel : rr_d;
        end else if (deliver) begin
            state_d = IDLE;
        end else if (expire) begin
            tgt_d = ~tgt_q;
        end

        if (clr_cnt) begin
            cnt_b_d = '0;
            cnt_c_d = '0;
        end else if (deliver) begin
            if (tgt_q == SEL_B && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
            if (tgt_q == SEL_C && cnt_c_q != CNT_MAX) cnt_c_d = cnt_c_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            tgt_q   <= SEL_B;
            mode_q  <= MODE_RR;
            rr_q    <= SEL_B;
            cnt_b_q <= '0;
            cnt_c_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            rr_q    <= rr_d;
            cnt_b_q <= cnt_b_d;
            cnt_c_q <= cnt_c_d;
        end
    end

    assign out_b_valid = (state_q == SEND) & (tgt_q == SEL_B);
    assign out_c_valid = (state_q == SEND) & (tgt_q == SEL_C);
    assign out_b_data  = out_b_valid ? hold_q : '0;
    assign out_c_data  = out_c_valid ? hold_q : '0;
    assign sel_o       = tgt_q;
    assign busy        = (state_q == SEND);
    assign cnt_b       = cnt_b_q;
    assign cnt_c       = cnt_c_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: a default instance plus a
// STALL_LIMIT=2 / CNT_W=2 instance sharing the same stimulus.
module tb_demux_dispatch_ctrl;

    typedef struct {
        logic       sink;
        logic [1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic       force_sel = 1'b0;
    logic       b_ready = 1'b0;
    logic       c_ready = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       in_ready1, b_valid1, c_valid1, sel1, busy1;
    logic [1:0] b_data1, c_data1;
    logic [7:0] cnt_b1, cnt_c1;
    logic       in_ready2, b_valid2, c_valid2, sel2, busy2;
    logic [1:0] b_data2, c_data2;
    logic [1:0] cnt_b2, cnt_c2;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic mon_sel = 1'b0;
    logic seen_b = 1'b0;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.DATA_W(2), .STALL_LIMIT(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .mode(mode), .force_sel(force_sel),
        .out_b_data(b_data1), .out_b_valid(b_valid1), .out_b_ready(b_ready),
        .out_c_data(c_data1), .out_c_valid(c_valid1), .out_c_ready(c_ready),
        .sel_o(sel1), .busy(busy1), .cnt_b(cnt_b1), .cnt_c(cnt_c1), .clr_cnt(clr_cnt)
    );

    demux_dispatch_ctrl #(.DATA_W(2), .STALL_LIMIT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .mode(mode), .force_sel(force_sel),
        .out_b_data(b_data2), .out_b_valid(b_valid2), .out_b_ready(b_ready),
        .out_c_data(c_data2), .out_c_valid(c_valid2), .out_c_ready(c_ready),
        .sel_o(sel2), .busy(busy2), .cnt_b(cnt_b2), .cnt_c(cnt_c2), .clr_cnt(clr_cnt)
    );

    logic       m_bv, m_cv;
    logic [1:0] m_bd, m_cd;
    exp_t       m_exp;

    // Scoreboard monitor: pops one expected word per delivery on the watched instance.
    always @(negedge clk) begin
        m_bv = mon_sel ? b_valid2 : b_valid1;
        m_cv = mon_sel ? c_valid2 : c_valid1;
        m_bd = mon_sel ? b_data2  : b_data1;
        m_cd = mon_sel ? c_data2  : c_data1;
        if (m_bv) seen_b = 1'b1;
        total_cnt++;
        if ((m_bv && m_cv) || (!m_bv && m_bd !== 2'd0) || (!m_cv && m_cd !== 2'd0))
            $display("[TB] FAIL steering t=%0t got bv=%0b cv=%0b bd=%0d cd=%0d, exp one valid and idle data 0",
                     $time, m_bv, m_cv, m_bd, m_cd);
        else
            pass_cnt++;
        if ((m_bv && b_ready) || (m_cv && c_ready)) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL delivery t=%0t got unexpected word on %s, exp none",
                         $time, m_bv ? "B" : "C");
            end else begin
                m_exp = sb.pop_front();
                if (m_bv !== (m_exp.sink == 1'b0) || (m_bv ? m_bd : m_cd) !== m_exp.data)
                    $display("[TB] FAIL delivery t=%0t got sink=%0d data=%0d, exp sink=%0d data=%0d",
                             $time, m_cv, m_bv ? m_bd : m_cd, m_exp.sink, m_exp.data);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic cur_ready();
        return mon_sel ? in_ready2 : in_ready1;
    endfunction

    task automatic send_word(input logic [1:0] d, input logic sink);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (cur_ready() !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            total_cnt++;
            $display("[TB] FAIL handshake_timeout got in_ready=0 for 20 cycles, exp 1");
        end else begin
            sb.push_back('{sink: sink, data: d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
        mode = 1'b0; force_sel = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if ({in_ready1, busy1, sel1, b_valid1, c_valid1} !== 5'b10000)
            $display("[TB] FAIL reset_ctrl got rdy/busy/sel/bv/cv=%b, exp 10000",
                     {in_ready1, busy1, sel1, b_valid1, c_valid1});
        else pass_cnt++;
        total_cnt++;
        if ({b_data1, c_data1, cnt_b1, cnt_c1, cnt_b2, cnt_c2} !== '0)
            $display("[TB] FAIL reset_data got bd=%0d cd=%0d cb=%0d cc=%0d, exp 0",
                     b_data1, c_data1, cnt_b1, cnt_c1);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        mon_sel = 1'b0;
        do_reset();
        b_ready = 1'b1; c_ready = 1'b1;
        send_word(2'd1, 1'b0);
        send_word(2'd2, 1'b1);
        send_word(2'd3, 1'b0);
        send_word(2'd0, 1'b1);
        in_valid = 1'b0;
        wait_cycles(3);
        total_cnt++;
        if (cnt_b1 !== 8'd2 || cnt_c1 !== 8'd2)
            $display("[TB] FAIL rr_counts got b=%0d c=%0d, exp b=2 c=2", cnt_b1, cnt_c1);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL rr_drain got %0d pending, exp 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_forced();
        mon_sel = 1'b0;
        do_reset();
        b_ready = 1'b1; c_ready = 1'b1;
        mode = 1'b1; force_sel = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 5; i++) send_word(2'(i), 1'b1);
        in_valid = 1'b0;
        wait_cycles(3);
        total_cnt++;
        if (cnt_c1 !== 8'd5 || cnt_b1 !== 8'd0)
            $display("[TB] FAIL forced_counts got b=%0d c=%0d, exp b=0 c=5", cnt_b1, cnt_c1);
        else pass_cnt++;
        total_cnt++;
        if (seen_b !== 1'b0) $display("[TB] FAIL forced_b_idle got b_valid seen=1, exp 0");
        else pass_cnt++;
    endtask

    task automatic test_stall_redirect();
        mon_sel = 1'b0;
        do_reset();
        b_ready = 1'b0; c_ready = 1'b1;
        send_word(2'd2, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (b_valid1 !== 1'b1 || c_valid1 !== 1'b0 || b_data1 !== 2'd2)
                $display("[TB] FAIL stall_hold[%0d] got bv=%0b cv=%0b bd=%0d, exp bv=1 cv=0 bd=2",
                         i, b_valid1, c_valid1, b_data1);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (c_valid1 !== 1'b1 || b_valid1 !== 1'b0 || c_data1 !== 2'd2)
            $display("[TB] FAIL stall_redirect got bv=%0b cv=%0b cd=%0d, exp bv=0 cv=1 cd=2",
                     b_valid1, c_valid1, c_data1);
        else pass_cnt++;
        wait_cycles(1);
        total_cnt++;
        if (cnt_c1 !== 8'd1 || cnt_b1 !== 8'd0)
            $display("[TB] FAIL stall_count got b=%0d c=%0d, exp b=0 c=1", cnt_b1, cnt_c1);
        else pass_cnt++;
        b_ready = 1'b1;
        send_word(2'd3, 1'b0);
        in_valid = 1'b0;
        wait_cycles(2);
        total_cnt++;
        if (cnt_b1 !== 8'd1) $display("[TB] FAIL stall_next_b got b=%0d, exp 1", cnt_b1);
        else pass_cnt++;
    endtask

    task automatic test_counters();
        mon_sel = 1'b1;
        do_reset();
        b_ready = 1'b1; c_ready = 1'b1;
        mode = 1'b1; force_sel = 1'b0;
        for (int i = 0; i < 5; i++) send_word(2'(i + 1), 1'b0);
        in_valid = 1'b0;
        wait_cycles(2);
        total_cnt++;
        if (cnt_b2 !== 2'd3) $display("[TB] FAIL cnt_saturate got %0d, exp 3", cnt_b2);
        else pass_cnt++;
        clr_cnt = 1'b1;
        wait_cycles(1);
        clr_cnt = 1'b0;
        total_cnt++;
        if (cnt_b2 !== 2'd0) $display("[TB] FAIL cnt_clear got %0d, exp 0", cnt_b2);
        else pass_cnt++;
        send_word(2'd1, 1'b0);
        in_valid = 1'b0;
        wait_cycles(2);
        total_cnt++;
        if (cnt_b2 !== 2'd1) $display("[TB] FAIL cnt_after_clear got %0d, exp 1", cnt_b2);
        else pass_cnt++;
        send_word(2'd2, 1'b0);
        in_valid = 1'b0;
        clr_cnt = 1'b1;
        wait_cycles(1);
        clr_cnt = 1'b0;
        total_cnt++;
        if (cnt_b2 !== 2'd0) $display("[TB] FAIL cnt_clear_wins got %0d, exp 0", cnt_b2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_send();
        mon_sel = 1'b0;
        do_reset();
        b_ready = 1'b1; c_ready = 1'b1;
        send_word(2'd1, 1'b0);
        in_valid = 1'b0;
        wait_cycles(2);
        b_ready = 1'b0; c_ready = 1'b0;
        send_word(2'd2, 1'b1);
        in_valid = 1'b0;
        total_cnt++;
        if (c_valid1 !== 1'b1 || busy1 !== 1'b1)
            $display("[TB] FAIL midsend_held got cv=%0b busy=%0b, exp 1 1", c_valid1, busy1);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        sb.delete();
        total_cnt++;
        if ({b_valid1, c_valid1, b_data1, c_data1, busy1} !== '0 || in_ready1 !== 1'b1 ||
            cnt_b1 !== 8'd0 || cnt_c1 !== 8'd0)
            $display("[TB] FAIL midsend_reset got bv=%0b cv=%0b rdy=%0b cb=%0d, exp 0 0 1 0",
                     b_valid1, c_valid1, in_ready1, cnt_b1);
        else pass_cnt++;
        wait_cycles(1);
        rst_n = 1'b1;
        b_ready = 1'b1; c_ready = 1'b1;
        send_word(2'd3, 1'b0);
        in_valid = 1'b0;
        wait_cycles(2);
        total_cnt++;
        if (cnt_b1 !== 8'd1 || cnt_c1 !== 8'd0)
            $display("[TB] FAIL midsend_next got b=%0d c=%0d, exp b=1 c=0", cnt_b1, cnt_c1);
        else pass_cnt++;
    endtask

    task automatic test_ping_pong();
        logic exp_c;
        mon_sel = 1'b1;
        do_reset();
        send_word(2'd3, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_c = ((i / 2) % 2) == 1;
            @(negedge clk);
            total_cnt++;
            if (b_valid2 !== ~exp_c || c_valid2 !== exp_c || in_ready2 !== 1'b0)
                $display("[TB] FAIL pingpong[%0d] got bv=%0b cv=%0b rdy=%0b, exp bv=%0b cv=%0b rdy=0",
                         i, b_valid2, c_valid2, in_ready2, ~exp_c, exp_c);
            else pass_cnt++;
        end
        total_cnt++;
        if (cnt_b2 !== 2'd0 || cnt_c2 !== 2'd0)
            $display("[TB] FAIL pingpong_idle_cnt got b=%0d c=%0d, exp 0 0", cnt_b2, cnt_c2);
        else pass_cnt++;
        wait_cycles(1);
        c_ready = 1'b1;
        wait_cycles(2);
        total_cnt++;
        if (cnt_c2 !== 2'd1 || cnt_b2 !== 2'd0)
            $display("[TB] FAIL pingpong_deliver got b=%0d c=%0d, exp b=0 c=1", cnt_b2, cnt_c2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_forced();
        test_stall_redirect();
        test_counters();
        test_reset_mid_send();
        test_ping_pong();
        total_cnt++;
        if (sb.size() != 0) $display("[TB] FAIL final_drain got %0d pending, exp 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for a 1-to-2 data demultiplexer. Accepts words from one upstream source over a valid/ready handshake and steers each word to sink B or sink C.
- Steering is either round-robin or forced by a select input.
- Redirects a word to the other sink after a bounded stall (round-robin only).
- Keeps per-sink dispatch counters. Sits between the demux datapath and its requesters/consumers.

Parameters:
- DATA_W, 2, width of the data word.
- STALL_LIMIT, 4, consecutive not-ready cycles on the target sink before redirection (round-robin mode); range 1..255.
- CNT_W, 8, width of each dispatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  upstream word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- mode  in  1  0 = round-robin, 1 = forced.
- force_sel  in  1  target in forced mode: 0 = B, 1 = C.
- out_b_data  out  DATA_W  word to sink B.
- out_b_valid  out  1  sink B word valid.
- out_b_ready  in  1  sink B accepts.
- out_c_data  out  DATA_W  word to sink C.
- out_c_valid  out  1  sink C word valid.
- out_c_ready  in  1  sink C accepts.
- sel_o  out  1  current/last target: 0 = B, 1 = C.
- busy  out  1  a word is held.
- cnt_b  out  CNT_W  words delivered to B, saturating.
- cnt_c  out  CNT_W  words delivered to C, saturating.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready = 1, all out_* valid/data = 0, sel_o = 0, busy = 0, cnt_b = cnt_c = 0, rr_ptr = 0 (B first), stall count = 0.
- States:
  - IDLE: in_ready = 1.
  - SEND: one word held in hold_reg; target register tgt.
- IDLE -> SEND on in_valid & in_ready. Capture in_data; tgt = force_sel if mode = 1, else rr_ptr. sel_o = tgt.
- In SEND, only the target output carries valid = 1 and data = hold_reg. The non-target output drives valid = 0 and data = 0, never stale data.
- Delivery occurs in a cycle where the target output has valid = 1 and its ready = 1. On delivery:
  - Increment the target counter, saturating at 2^CNT_W - 1.
  - In round-robin mode, rr_ptr = ~tgt.
  - Clear the stall count.
- Back-to-back: in SEND, in_ready = delivery that cycle. If in_valid is also high, capture the next word and stay in SEND, with the new tgt computed from the updated rr_ptr. Otherwise go to IDLE. Sustained throughput is 1 word/cycle; latency from in handshake to out valid is 1 cycle.
- Stall redirection (round-robin only):
  - Stall count increments each SEND cycle the target is not ready.
  - When it reaches STALL_LIMIT: tgt flips, the stall count clears, and rr_ptr is unchanged by the redirect.
  - The old output drops valid in the same cycle the new output raises it. Sinks must tolerate valid retraction.
  - If both sinks stay not-ready, the word ping-pongs every STALL_LIMIT cycles and is never dropped.
- Forced mode: no redirection; the word waits indefinitely.
- mode and force_sel are sampled only at word capture. A change while in SEND affects the next word only.
- The ready of the non-target sink is ignored.
- clr_cnt: counters = 0 next cycle. Clear wins over a simultaneous increment.
- Reset mid-SEND: the held word is discarded; no output valid after reset.
- busy = (state == SEND).

Decomposition:
- Package demux_dispatch_pkg:
  - state enum {IDLE, SEND};
  - constants SEL_B = 1'b0, SEL_C = 1'b1;
  - MODE_RR = 1'b0, MODE_FORCED = 1'b1.
- One sub-module, demux_stall_timer: parameterised down-counter with load, enable and expiry pulse. It is instantiated once for the redirection logic.
- Output steering and the counters stay in the top module.

Test Plan:
- Reset, mode = 0, both sinks ready, in_valid held with data 1,2,3,0 -> B gets 1, C gets 2, B gets 3, C gets 0 on consecutive cycles; cnt_b = 2, cnt_c = 2; non-target data always 0.
- mode = 1, force_sel = 1, 5 words, C ready -> all 5 on C; cnt_c = 5; out_b_valid never 1.
- mode = 0, target B with out_b_ready = 0 and C ready, STALL_LIMIT = 4 -> out_b_valid high for 4 cycles, then out_c_valid high with the same word; delivered on C; cnt_c = 1; next word targets B (rr_ptr unchanged by redirect).
- Counters: CNT_W = 2, 5 words forced to B -> cnt_b saturates at 3. clr_cnt asserted in the same cycle as a delivery -> cnt_b = 0.
- Assert rst_n low mid-SEND with a word held -> all valids and data 0, in_ready = 1, counters 0, next word goes to B.
- Both sinks not ready, mode = 0, STALL_LIMIT = 2 -> valid alternates B,B,C,C,B,B...; in_ready stays 0; no counter change until a ready arrives.
